mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instruction opcode field (IR[31:26]), sampled only in DECODE.
REQ-005 zero  in  1  ALU zero flag, used only in BEQEX.
REQ-006 pcen  out  1  PC register enable = pcwrite OR (branch AND zero).
REQ-007 irwrite  out  1  instruction register enable.
REQ-008 memwrite  out  1  data memory write strobe.
REQ-009 regwrite  out  1  register file write enable.
REQ-010 iord, alusrca, regdst, memtoreg  out  1 each  datapath mux selects.
REQ-011 alusrcb, pcsrc, aluop  out  2 each  datapath mux selects / ALU op class.
REQ-012 state  out  4  current state encoding, debug/verification visibility.
REQ-013 illegal  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-014 SHALL be a Moore FSM; every output except pcen SHALL be a pure decode of state; pcen SHALL be combinational from state and zero.
REQ-015 States/encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, ILLEGAL=12; encodings 13-15 are unreachable.
REQ-016 Transitions: FETCH->DECODE; DECODE->MEMADR (op 100011 lw or 101011 sw), RTYPEEX (000000), BEQEX (000100), ADDIEX (001000), JEX (000010), ILLEGAL (any other op).
REQ-017 MEMADR->MEMRD (lw) or MEMWR (sw), using op held stable by the IR; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
REQ-018 MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX, ILLEGAL SHALL all go to FETCH.
REQ-019 Unreachable encodings 13-15 SHALL go to FETCH with all outputs 0.
REQ-020 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
REQ-021 DECODE: alusrca=0, alusrcb=11, aluop=00.
REQ-022 MEMADR: alusrca=1, alusrcb=10, aluop=00.
REQ-023 MEMRD: iord=1.
REQ-024 MEMWB: regdst=0, memtoreg=1, regwrite=1.
REQ-025 MEMWR: iord=1, memwrite=1.
REQ-026 RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
REQ-027 RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
REQ-028 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
REQ-029 ADDIEX: alusrca=1, alusrcb=10, aluop=00.
REQ-030 ADDIWB: regdst=0, memtoreg=0, regwrite=1.
REQ-031 JEX: pcsrc=10, pcwrite=1.
REQ-032 ILLEGAL: illegal=1 for exactly one cycle; no write strobe asserted.
REQ-033 Any output not listed for a state SHALL be 0.
REQ-034 Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3.
REQ-035 At most one of irwrite, memwrite, regwrite SHALL be high in any cycle.

Reset
REQ-036 reset sampled high at a clk edge SHALL force state=FETCH from any state, including mid-instruction, aborting it with no further write strobes.
REQ-037 While reset is held, outputs SHALL show FETCH decode; downstream registers SHALL give their own reset priority over the pcen/irwrite enables.
REQ-038 The first FETCH after reset deassertion SHALL last one cycle.

Structure
REQ-039 State encodings, opcode constants, and the alusrcb/pcsrc/aluop encodings SHALL live in the shared package mips_pkg.
REQ-040 The block SHALL contain a state register, next-state logic, and output decode; the state register SHALL instantiate the existing 4-bit dff with en=1.
REQ-041 No other sub-module is required.

Verification
REQ-042 reset=1 for 3 cycles, then op=100011 (lw) -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-043 op=101011 (sw) -> states 0,1,2,5,0; memwrite=1 for exactly 1 cycle with iord=1.
REQ-044 op=000100 (beq), zero=1 in BEQEX -> pcen=1, pcsrc=01; repeat with zero=0 -> pcen=0 in BEQEX.
REQ-045 op=000010 (j) -> states 0,1,11,0; pcen=1 and pcsrc=10 in JEX; op=111111 -> illegal pulses once, then FETCH.
REQ-046 reset asserted in MEMRD during lw -> next state FETCH; regwrite never asserted for that instruction.
REQ-047 Back-to-back R-type, addi, lw run -> total cycles 4+4+5=13; the write-strobe exclusivity assertion holds throughout.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: controller state encodings, opcodes,
// and datapath mux/ALU-class encodings.
package mips_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11,
      ILLEGAL = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALUSRCB_REG   = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/dff.sv
// Generic register with synchronous active-high reset and load enable.
module dff #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Reset wins over the enable.
   always_comb begin
      q_d = q_q;
      if (reset)
         q_d = '0;
      else if (en)
         q_d = d;
   end

   always_ff @(posedge clk)
      q_q <= q_d;

   assign q = q_q;

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main controller: Moore FSM whose outputs decode the state,
// except pcen which also folds in the ALU zero flag for branches.
module mc_control
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   output logic       pcen,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       alusrca,
   output logic       regdst,
   output logic       memtoreg,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic [3:0] state,
   output logic       illegal
);

   state_t     state_d;
   logic [3:0] state_q;
   logic       pcwrite;
   logic       branch;

   dff #(.WIDTH(4)) u_state_reg (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .d     (state_d),
      .q     (state_q)
   );

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
               default:      state_d = ILLEGAL;
            endcase
         end
         // op is still the IR copy captured for this instruction
         MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = MEMWB;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      iord     = 1'b0;
      alusrca  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrcb  = ALUSRCB_REG;
      pcsrc    = PCSRC_ALU;
      aluop    = ALUOP_ADD;
      illegal  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      case (state_q)
         FETCH: begin
            alusrcb = ALUSRCB_FOUR;
            irwrite = 1'b1;
            pcwrite = 1'b1;
         end
         DECODE:  alusrcb = ALUSRCB_IMMSH;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = ALUSRCB_IMM;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = ALUSRCB_IMM;
         end
         ADDIWB:  regwrite = 1'b1;
         JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
         end
         ILLEGAL: illegal = 1'b1;
         default: ;
      endcase
   end

   assign pcen  = pcwrite | (branch & zero);
   assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control: walks each instruction class,
// mid-instruction reset and a back-to-back run against hand-written decodes.
module tb_mc_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       zero;
   logic       pcen, irwrite, memwrite, regwrite;
   logic       iord, alusrca, regdst, memtoreg;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic [3:0] state;
   logic       illegal;

   int checks = 0;
   int errors = 0;
   int regwrite_cnt;
   int memwrite_cnt;
   int illegal_cnt;
   int cycle_cnt;

   mc_control dut (
      .clk      (clk),
      .reset    (reset),
      .op       (op),
      .zero     (zero),
      .pcen     (pcen),
      .irwrite  (irwrite),
      .memwrite (memwrite),
      .regwrite (regwrite),
      .iord     (iord),
      .alusrca  (alusrca),
      .regdst   (regdst),
      .memtoreg (memtoreg),
      .alusrcb  (alusrcb),
      .pcsrc    (pcsrc),
      .aluop    (aluop),
      .state    (state),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   // Expected output vector, in the order
   // {pcen,irwrite,memwrite,regwrite,iord,alusrca,regdst,memtoreg,alusrcb,pcsrc,aluop,illegal}
   function automatic logic [14:0] exp_outs(input logic [3:0] s, input logic z);
      case (s)
         4'd0:    return 15'b1_1_0_0_0_0_0_0_01_00_00_0;
         4'd1:    return 15'b0_0_0_0_0_0_0_0_11_00_00_0;
         4'd2:    return 15'b0_0_0_0_0_1_0_0_10_00_00_0;
         4'd3:    return 15'b0_0_0_0_1_0_0_0_00_00_00_0;
         4'd4:    return 15'b0_0_0_1_0_0_0_1_00_00_00_0;
         4'd5:    return 15'b0_0_1_0_1_0_0_0_00_00_00_0;
         4'd6:    return 15'b0_0_0_0_0_1_0_0_00_00_10_0;
         4'd7:    return 15'b0_0_0_1_0_0_1_0_00_00_00_0;
         4'd8:    return {z, 14'b0_0_0_0_1_0_0_00_01_01_0};
         4'd9:    return 15'b0_0_0_0_0_1_0_0_10_00_00_0;
         4'd10:   return 15'b0_0_0_1_0_0_0_0_00_00_00_0;
         4'd11:   return 15'b1_0_0_0_0_0_0_0_00_10_00_0;
         4'd12:   return 15'b0_0_0_0_0_0_0_0_00_00_00_1;
         default: return 15'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then check state, the full decode and strobe exclusivity.
   task automatic step(input logic [3:0] exp_state, input string tag);
      @(posedge clk);
      #1;
      cycle_cnt++;
      if (regwrite === 1'b1) regwrite_cnt++;
      if (memwrite === 1'b1) memwrite_cnt++;
      if (illegal === 1'b1)  illegal_cnt++;
      check({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
      check({tag, ".outs"},
            {17'd0, pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg,
             alusrcb, pcsrc, aluop, illegal},
            {17'd0, exp_outs(exp_state, zero)});
      check({tag, ".excl"}, {30'd0, 2'(irwrite + memwrite + regwrite) <= 2'd1}, 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      op    = 6'b000000;
      zero  = 1'b0;
      regwrite_cnt = 0;
      memwrite_cnt = 0;
      illegal_cnt  = 0;
      cycle_cnt    = 0;

      step(4'd0, "rst1");
      step(4'd0, "rst2");
      step(4'd0, "rst3");
      check("rst.irwrite", {31'd0, irwrite}, 32'd1);

      // lw: 0,1,2,3,4,0
      reset = 1'b0;
      op    = 6'b100011;
      regwrite_cnt = 0;
      step(4'd1, "lw.decode");
      step(4'd2, "lw.memadr");
      step(4'd3, "lw.memrd");
      step(4'd4, "lw.memwb");
      check("lw.memtoreg", {31'd0, memtoreg}, 32'd1);
      step(4'd0, "lw.fetch");
      check("lw.regwrite_cnt", regwrite_cnt, 32'd1);

      // sw: 0,1,2,5,0
      op = 6'b101011;
      memwrite_cnt = 0;
      step(4'd1, "sw.decode");
      step(4'd2, "sw.memadr");
      step(4'd5, "sw.memwr");
      check("sw.iord", {31'd0, iord}, 32'd1);
      step(4'd0, "sw.fetch");
      check("sw.memwrite_cnt", memwrite_cnt, 32'd1);

      // beq taken, then not taken
      op   = 6'b000100;
      zero = 1'b1;
      step(4'd1, "beqt.decode");
      step(4'd8, "beqt.beqex");
      check("beqt.pcen", {31'd0, pcen}, 32'd1);
      check("beqt.pcsrc", {30'd0, pcsrc}, 32'd1);
      step(4'd0, "beqt.fetch");
      zero = 1'b0;
      step(4'd1, "beqn.decode");
      step(4'd8, "beqn.beqex");
      check("beqn.pcen", {31'd0, pcen}, 32'd0);
      step(4'd0, "beqn.fetch");

      // j: 0,1,11,0
      op = 6'b000010;
      step(4'd1, "j.decode");
      step(4'd11, "j.jex");
      check("j.pcen", {31'd0, pcen}, 32'd1);
      check("j.pcsrc", {30'd0, pcsrc}, 32'd2);
      step(4'd0, "j.fetch");

      // unsupported opcode
      op = 6'b111111;
      illegal_cnt = 0;
      step(4'd1, "ill.decode");
      step(4'd12, "ill.illegal");
      step(4'd0, "ill.fetch");
      check("ill.pulse_cnt", illegal_cnt, 32'd1);

      // reset during MEMRD of a lw aborts it with no regwrite
      op = 6'b100011;
      regwrite_cnt = 0;
      step(4'd1, "abt.decode");
      step(4'd2, "abt.memadr");
      step(4'd3, "abt.memrd");
      reset = 1'b1;
      step(4'd0, "abt.reset");
      check("abt.regwrite_cnt", regwrite_cnt, 32'd0);
      reset = 1'b0;

      // back-to-back R-type, addi, lw: 4 + 4 + 5 cycles
      cycle_cnt = 0;
      op = 6'b000000;
      step(4'd1, "b2b.r.decode");
      step(4'd6, "b2b.r.ex");
      step(4'd7, "b2b.r.wb");
      step(4'd0, "b2b.r.fetch");
      op = 6'b001000;
      step(4'd1, "b2b.addi.decode");
      step(4'd9, "b2b.addi.ex");
      step(4'd10, "b2b.addi.wb");
      step(4'd0, "b2b.addi.fetch");
      op = 6'b100011;
      step(4'd1, "b2b.lw.decode");
      step(4'd2, "b2b.lw.memadr");
      step(4'd3, "b2b.lw.memrd");
      step(4'd4, "b2b.lw.memwb");
      step(4'd0, "b2b.lw.fetch");
      check("b2b.cycles", cycle_cnt, 32'd13);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
